// File: rtl/dmem_lsu_if.sv
// Request/response/SRAM bundle between the MEM stage, the load/store unit and the data SRAM.
// Latency: none, wires only.
// Backpressure: carries valid/ready on the request and response channels; the SRAM port has none.
interface dmem_lsu_if #(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 64
);
    logic                req_valid;
    logic                req_ready;
    logic [LEN_ADDR-1:0] req_addr;
    logic                req_wen;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [LEN_DATA-1:0] req_wdata;

    logic                resp_valid;
    logic                resp_ready;
    logic [LEN_DATA-1:0] resp_rdata;
    logic                resp_misalign;

    logic [LEN_ADDR-1:0] sram_addr;
    logic                sram_en;
    logic [7:0]          sram_we;
    logic [LEN_DATA-1:0] sram_din;
    logic [LEN_DATA-1:0] sram_dout;

    // Requester side: MEM stage plus the SRAM macro's read port.
    modport master (
        output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misalign,
        output resp_ready,
        input  sram_addr, sram_en, sram_we, sram_din,
        output sram_dout
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misalign,
        input  resp_ready,
        output sram_addr, sram_en, sram_we, sram_din,
        input  sram_dout
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: drives byte-lane SRAM writes/reads, extends load lanes, traps misaligned accesses.
// Latency: response one cycle after accept; SRAM port driven combinationally in the accept cycle.
// Backpressure: a stalled response is parked in hold registers and blocks new requests until taken.
module dmem_lsu #(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 64
) (
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [2:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                wen_q, wen_d;
    logic                mis_q, mis_d;
    logic [LEN_DATA-1:0] hold_rdata_q, hold_rdata_d;
    logic                hold_mis_q, hold_mis_d;

    logic [2:0]          req_off;
    logic [2:0]          align_mask;
    logic [7:0]          size_mask;
    logic                req_mis;
    logic                req_ready_int;
    logic                fire;
    logic [LEN_DATA-1:0] lane;
    logic [LEN_DATA-1:0] fmt_rdata;

    // Decode the incoming request: lane offset, byte mask and alignment trap.
    always_comb begin
        req_off = bus.req_addr[2:0];
        case (bus.req_size)
            2'd0:    begin size_mask = 8'h01; align_mask = 3'b000; end
            2'd1:    begin size_mask = 8'h03; align_mask = 3'b001; end
            2'd2:    begin size_mask = 8'h0F; align_mask = 3'b011; end
            default: begin size_mask = 8'hFF; align_mask = 3'b111; end
        endcase
        req_mis = (req_off & align_mask) != 3'b000;
    end

    // Ready while idle, or when the pending response is being taken this cycle; never in reset.
    always_comb begin
        case (state_q)
            S_IDLE:  req_ready_int = 1'b1;
            default: req_ready_int = bus.resp_ready;
        endcase
        req_ready_int = req_ready_int & ~rst;
        fire          = bus.req_valid & req_ready_int;
    end

    // Format the SRAM word for the captured access: shift lane down, truncate, extend.
    always_comb begin
        lane = bus.sram_dout >> {off_q, 3'b000};
        case (size_q)
            2'd0:    fmt_rdata = {{56{~uns_q & lane[7]}},  lane[7:0]};
            2'd1:    fmt_rdata = {{48{~uns_q & lane[15]}}, lane[15:0]};
            2'd2:    fmt_rdata = {{32{~uns_q & lane[31]}}, lane[31:0]};
            default: fmt_rdata = lane;
        endcase
        if (wen_q || mis_q) begin
            fmt_rdata = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request fields and parked response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wen_q        <= 1'b0;
            mis_q        <= 1'b0;
            hold_rdata_q <= '0;
            hold_mis_q   <= 1'b0;
        end else begin
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wen_q        <= wen_d;
            mis_q        <= mis_d;
            hold_rdata_q <= hold_rdata_d;
            hold_mis_q   <= hold_mis_d;
        end
    end

    // Next state, capture on accept, park the formatted response when the consumer stalls.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wen_d        = wen_q;
        mis_d        = mis_q;
        hold_rdata_d = hold_rdata_q;
        hold_mis_d   = hold_mis_q;
        if (fire) begin
            off_d  = req_off;
            size_d = bus.req_size;
            uns_d  = bus.req_unsigned;
            wen_d  = bus.req_wen;
            mis_d  = req_mis;
        end
        case (state_q)
            S_IDLE: begin
                if (fire) state_d = S_DATA;
            end
            S_DATA: begin
                if (bus.resp_ready) begin
                    state_d = fire ? S_DATA : S_IDLE;
                end else begin
                    // SRAM output is only valid this cycle, so park the formatted result.
                    hold_rdata_d = fmt_rdata;
                    hold_mis_d   = mis_q;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.resp_ready) state_d = fire ? S_DATA : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive the request/response channels and the SRAM port.
    always_comb begin
        bus.req_ready = req_ready_int;
        case (state_q)
            S_DATA: begin
                bus.resp_valid    = 1'b1;
                bus.resp_rdata    = fmt_rdata;
                bus.resp_misalign = mis_q;
            end
            S_HOLD: begin
                bus.resp_valid    = 1'b1;
                bus.resp_rdata    = hold_rdata_q;
                bus.resp_misalign = hold_mis_q;
            end
            default: begin
                bus.resp_valid    = 1'b0;
                bus.resp_rdata    = '0;
                bus.resp_misalign = 1'b0;
            end
        endcase
        bus.sram_en   = fire & ~req_mis;
        bus.sram_addr = rst ? '0 : {bus.req_addr[LEN_ADDR-1:3], 3'b000};
        bus.sram_we   = (bus.sram_en & bus.req_wen) ? (size_mask << req_off) : 8'h00;
        bus.sram_din  = bus.sram_en ? (bus.req_wdata << {req_off, 3'b000}) : '0;
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array reference model plus SRAM model, checked every response cycle.
// Latency: expects responses exactly one cycle after accept.
// Backpressure: exercises stalls, same-cycle handshake/accept and reset while a response is parked.
module tb_dmem_lsu;
    localparam int LA = 32;
    localparam int LD = 64;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          cyc;
        logic        has_lit;
        logic [63:0] lit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_fire = 0;
    logic [7:0]  last_we;
    logic [63:0] last_din;
    logic        prev_stall = 1'b0;

    exp_t        expq[$];
    logic [7:0]  ref_mem [0:255];
    logic [63:0] sram_mem [0:31];
    logic [63:0] sram_q;

    always #5 clk = ~clk;

    dmem_lsu_if #(.LEN_ADDR(LA), .LEN_DATA(LD)) bus();

    dmem_lsu #(.LEN_ADDR(LA), .LEN_DATA(LD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, 0 when not enabled, byte-lane writes.
    always @(posedge clk) begin
        if (init) begin
            for (int w = 0; w < 32; w++) sram_mem[w] <= 64'h0;
            sram_mem[1] <= 64'h8877_6655_4433_2211;
            sram_q      <= 64'h0;
        end else if (bus.sram_en) begin
            sram_q <= sram_mem[bus.sram_addr[7:3]];
            for (int b = 0; b < 8; b++)
                if (bus.sram_we[b]) sram_mem[bus.sram_addr[7:3]][8*b +: 8] <= bus.sram_din[8*b +: 8];
        end else begin
            sram_q <= 64'h0;
        end
    end
    assign bus.sram_dout = sram_q;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Drive one request, wait for accept, check SRAM drive, update reference model.
    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] wd, input logic hl, input logic [63:0] lit);
        int          n;
        int          off;
        logic        mis;
        logic [63:0] v;
        logic [63:0] we_want;
        exp_t        e;
        bit          done = 0;
        n   = 1 << sz;
        off = a % 8;
        mis = (a % n) != 0;
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_wen      = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_wdata    = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                done = 1;
                last_fire = cyc;
                chk("sram_en", bus.sram_en, !mis);
                chk("sram_addr", bus.sram_addr, a & ~32'h7);
                we_want = (w && !mis) ? (((64'h1 << n) - 1) << off) : 64'h0;
                chk("sram_we", bus.sram_we, we_want);
                chk("sram_din", bus.sram_din, mis ? 64'h0 : (wd << (8 * off)));
                last_we  = bus.sram_we;
                last_din = bus.sram_din;
                v = 64'h0;
                if (!mis && !w) begin
                    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + i)];
                    if (!u && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
                end
                if (!mis && w) for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wd[8*i +: 8];
                e.rdata = v; e.mis = mis; e.cyc = cyc + 1; e.has_lit = hl; e.lit = lit;
                expq.push_back(e);
            end
        end
        if (!done) chk("accept_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (expq.size() == 0) ok = 1;
        end
        chk("drain", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_misalign", bus.resp_misalign, 0);
        chk("rst_sram_en", bus.sram_en, 0);
        chk("rst_sram_we", bus.sram_we, 0);
        chk("rst_sram_addr", bus.sram_addr, 0);
        chk("rst_sram_din", bus.sram_din, 0);
    endtask

    // Compare process: every response cycle against the model's head entry.
    always @(negedge clk) begin
        if (rst || init) begin
            prev_stall <= 1'b0;
        end else begin
            chk("req_ready_rule", bus.req_ready, !bus.resp_valid || bus.resp_ready);
            if (bus.sram_en) chk("sram_en_no_fire", bus.req_valid & bus.req_ready, 1);
            if (bus.resp_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_resp", 64'h1, 64'h0);
                end else begin
                    if (!prev_stall) chk("resp_latency", cyc, expq[0].cyc);
                    chk("resp_rdata", bus.resp_rdata, expq[0].rdata);
                    chk("resp_misalign", bus.resp_misalign, expq[0].mis);
                    if (bus.resp_ready) begin
                        if (expq[0].has_lit) chk("resp_literal", bus.resp_rdata, expq[0].lit);
                        void'(expq.pop_front());
                        prev_stall <= 1'b0;
                    end else begin
                        prev_stall <= 1'b1;
                    end
                end
            end else begin
                prev_stall <= 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

    initial begin
        int first;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) ref_mem[8 + i] = 8'(8'h11 * (i + 1));
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b0;

        // Reset state
        #1;
        chk_all_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Load extension
        issue(32'h0F, 0, 2'd0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF88);
        issue(32'h0F, 0, 2'd0, 1, 64'h0, 1, 64'h0000_0000_0000_0088);
        issue(32'h0A, 0, 2'd1, 0, 64'h0, 1, 64'h0000_0000_0000_4433);
        issue(32'h0C, 0, 2'd2, 0, 64'h0, 1, 64'hFFFF_FFFF_8877_6655);
        issue(32'h08, 0, 2'd3, 0, 64'h0, 1, 64'h8877_6655_4433_2211);
        drain();

        // Byte-lane stores then merged readback
        issue(32'h13, 1, 2'd0, 0, 64'hAB, 1, 64'h0);
        chk("sb_we_lit", last_we, 64'h08);
        chk("sb_din_lit", last_din, 64'hAB00_0000);
        issue(32'h16, 1, 2'd1, 0, 64'h1234, 1, 64'h0);
        chk("sh_we_lit", last_we, 64'hC0);
        issue(32'h10, 0, 2'd3, 0, 64'h0, 1, 64'h1234_0000_AB00_0000);
        drain();

        // Misaligned accesses leave SRAM untouched
        issue(32'h01, 0, 2'd1, 0, 64'h0, 1, 64'h0);
        issue(32'h06, 0, 2'd2, 0, 64'h0, 1, 64'h0);
        issue(32'h04, 1, 2'd3, 0, 64'hDEAD_BEEF_DEAD_BEEF, 1, 64'h0);
        issue(32'h00, 0, 2'd3, 0, 64'h0, 1, 64'h0);
        issue(32'h08, 0, 2'd3, 0, 64'h0, 1, 64'h8877_6655_4433_2211);
        drain();

        // Back-to-back loads
        first = 0;
        for (int i = 0; i < 8; i++) begin
            issue(32'h08 + i, 0, 2'd0, (i % 2) == 0, 64'h0, 0, 64'h0);
            if (i == 0) first = last_fire;
        end
        chk("b2b_span", last_fire - first, 7);
        drain();

        // Backpressure: 3 stalled cycles, then handshake and accept together
        bus.resp_ready = 1'b0;
        issue(32'h0E, 0, 2'd1, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8877);
        first = last_fire;
        fork
            issue(32'h08, 0, 2'd2, 1, 64'h0, 1, 64'h0000_0000_4433_2211);
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 bus.resp_ready = 1'b1;
            end
        join
        chk("bp_accept_cycle", last_fire - first, 4);
        drain();

        // Reset while a store response is parked
        issue(32'h20, 1, 2'd2, 0, 64'hCAFE_F00D, 1, 64'h0);
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_all_zero();
        expq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rel_req_ready", bus.req_ready, 1);
        chk("rel_resp_valid", bus.resp_valid, 0);
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(32'h20, 0, 2'd2, 1, 64'h0, 1, 64'h0000_0000_CAFE_F00D);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
